// File: rtl/serial_adder_n_bit.sv
// serial_adder_n_bit: multi-cycle adder, DIGIT bits per clock through a full-adder chain with registered carry.
// Optional subtract mode (B inverted, carry-in forced to 1) enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_n_bit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_INPUT_A,
    input  logic [WIDTH-1:0] i_INPUT_B,
    input  logic             i_LOWER_CARRY,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             i_SUB,
`endif
    output logic [WIDTH-1:0] o_FULL_SUM,
    output logic             o_FULL_CARRY,
    output logic             o_OVF,
    output logic             o_DONE
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_nxt, b_sel;
    logic             carry_q, carry_d, fcarry_q, fcarry_d, ovf_q, ovf_d, cin_sel, last;
    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] s;

    assign c[0] = carry_q;
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        assign s[g]   = a_q[g] ^ b_q[g] ^ c[g];
        assign c[g+1] = (a_q[g] & b_q[g]) | (c[g] & (a_q[g] ^ b_q[g]));
    end

    // New digit enters at the top; after N steps the first digit has reached bit 0.
    if (DIGIT == WIDTH) begin : g_full
        assign acc_nxt = s;
    end else begin : g_part
        assign acc_nxt = {s, acc_q[WIDTH-1:DIGIT]};
    end

`ifdef SERIAL_ADDER_SUB_EN
    assign b_sel   = i_SUB ? ~i_INPUT_B : i_INPUT_B;
    assign cin_sel = i_SUB ? 1'b1 : i_LOWER_CARRY;
`else
    assign b_sel   = i_INPUT_B;
    assign cin_sel = i_LOWER_CARRY;
`endif

    assign last = (state_q == S_RUN) && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        fcarry_d = fcarry_q;
        ovf_d    = ovf_q;
        if (state_q == S_IDLE && i_VALID) begin
            a_d     = i_INPUT_A;
            b_d     = b_sel;
            carry_d = cin_sel;
            cnt_d   = '0;
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            acc_d   = acc_nxt;
            carry_d = c[DIGIT];
            cnt_d   = cnt_q + 1'b1;
            if (last) begin
                state_d  = S_DONE;
                sum_d    = acc_nxt;
                fcarry_d = c[DIGIT];
                ovf_d    = c[DIGIT] ^ c[DIGIT-1];
            end
        end else if (state_q == S_DONE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            fcarry_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            fcarry_q <= fcarry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign o_READY      = state_q == S_IDLE;
    assign o_DONE       = state_q == S_DONE;
    assign o_FULL_SUM   = sum_q;
    assign o_FULL_CARRY = fcarry_q;
    assign o_OVF        = ovf_q;
endmodule

// File: doc/serial_adder_n_bit.md
# serial_adder_n_bit

Parametrised multi-cycle adder for the ALU datapath that adds two WIDTH-bit operands DIGIT bits per clock, using a chain of DIGIT 1-bit full-adder cells and a registered carry between steps. Operands are captured on a valid/ready handshake, and the result is presented with a one-cycle done pulse. It replaces wide combinational ripple adders where area matters more than latency.

## Interface
- WIDTH, 8: operand and sum width in bits; must be at least 2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly. N = WIDTH/DIGIT is the number of step cycles.
- i_CLK  input  1  rising-edge clock.
- i_RST  input  1  asynchronous, active-high reset.
- i_VALID  input  1  operands and mode valid; accepted only while o_READY=1.
- o_READY  output  1  high only in IDLE.
- i_INPUT_A  input  WIDTH  operand A, unsigned or two's complement.
- i_INPUT_B  input  WIDTH  operand B.
- i_LOWER_CARRY  input  1  carry-in for the addition.
- i_SUB  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- o_FULL_SUM  output  WIDTH  result.
- o_FULL_CARRY  output  1  carry-out of the MSB.
- o_OVF  output  1  signed overflow.
- o_DONE  output  1  one-cycle pulse; result registers update on the same edge that raises it.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **IDLE**
  - o_READY=1.
  - When i_VALID=1 at a rising edge:
    - A, B (or ~B in subtract mode) and the carry-in are latched into shift registers.
    - The step counter is cleared.
    - The state moves to RUN.
  - When i_VALID=0, the state stays in IDLE.
- **RUN**
  - On each edge, the DIGIT LSBs of the A and B shift registers pass through the full-adder chain with the registered carry.
  - The DIGIT-bit sum is shifted into the top of the sum register; A and B shift right by DIGIT.
  - The carry register takes the chain's carry-out, and the counter increments.
  - On the Nth step edge, the state moves to DONE, and on that same edge:
    - o_FULL_SUM loads the completed sum.
    - o_FULL_CARRY loads the final carry.
    - o_OVF loads the XOR of the carry into and out of the MSB.
- **DONE**
  - o_DONE=1 for exactly one cycle, then the state returns to IDLE.
- i_VALID and operand changes outside IDLE are ignored; there is no queuing.
- o_FULL_SUM, o_FULL_CARRY and o_OVF hold their values until the next DONE entry.
- Arithmetic:
  - Sum = (A + B' + cin) mod 2^WIDTH.
  - o_FULL_CARRY = bit WIDTH of the exact sum.
  - No sign extension is applied.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - State goes to IDLE, and the counter, carry and shift registers clear.
  - Outputs after reset: o_FULL_SUM=0, o_FULL_CARRY=0, o_OVF=0, o_DONE=0, o_READY=1.
  - Any in-flight operation is discarded, with no o_DONE.
- Latency:
  - With the accept edge as E0, the step edges are E1..EN.
  - o_DONE is high in the cycle following EN.
  - o_READY is low for N+1 cycles.
- Throughput: one operation per N+2 cycles. The earliest next accept is the edge that ends DONE+1; i_VALID held high is accepted again on the first edge at which o_READY=1.
- For WIDTH=8: DIGIT=1 gives N=8; DIGIT=4 gives N=2; DIGIT=8 gives N=1, which is a single-step operation that still passes through DONE.
- o_READY and o_DONE are decoded from the state register; they carry no combinational path from the inputs.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- **With the macro defined:**
  - The i_SUB port exists.
  - When i_SUB=1 at accept, B is latched as ~B and the carry-in is forced to 1, ignoring i_LOWER_CARRY.
  - o_FULL_CARRY=1 then means no borrow.
  - o_OVF is computed identically in both modes.
- **Without the macro:**
  - No i_SUB port and no inversion logic.
  - Add only, with i_LOWER_CARRY always used.

## Test plan
- Test plan parameters: WIDTH=8, DIGIT=1 unless stated otherwise.
- Basic add with carry: accept A=0x0F, B=0x01, cin=0 -> o_DONE in the 9th cycle after accept, o_FULL_SUM=0x10, o_FULL_CARRY=0, o_OVF=0; o_READY=0 throughout, returning to 1 one cycle after o_DONE.
- Wrap and overflow:
  - A=0xFF, B=0x01, cin=0 -> sum 0x00, carry 1, ovf 0.
  - A=0x7F, B=0x00, cin=1 -> sum 0x80, carry 0, ovf 1.
- DIGIT=4: A=0xA5, B=0x5B, cin=1 -> sum 0x01, carry 1, with o_DONE 3 cycles after accept; DIGIT=8 gives the same result with o_DONE 2 cycles after accept.
- Busy and back-to-back:
  - Hold i_VALID=1 with operands changing every cycle -> only the accept-time operands affect the result.
  - A second accept occurs exactly when o_READY returns to 1.
  - The prior result is held until the second o_DONE.
- Reset mid-RUN: assert i_RST at step 4 -> o_READY=1 and all outputs 0 immediately; no o_DONE follows; the next operation, 0x03+0x04, produces 0x07.
- SERIAL_ADDER_SUB_EN builds:
  - i_SUB=1, A=0x05, B=0x07 -> sum 0xFE, carry 0.
  - i_SUB=1, A=0x80, B=0x01 -> sum 0x7F, carry 1, ovf 1.
